// File: rtl/bcd_opc_checker.sv
// Receive-side checker for 5-bit BCD odd-parity serial frames (b3..b0 then parity).
// Presents each completed digit with parity/range flags and a saturating bad-frame count.
module bcd_opc_checker (
  input  logic       clock,
  input  logic       reset,
  input  logic       x,
  input  logic       en,
  output logic [3:0] digit,
  output logic       valid,
  output logic       parity_err,
  output logic       range_err,
  output logic [3:0] err_cnt
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;

  state_t     state_reg, state_next;
  logic [3:0] shift_reg, shift_next;
  logic [3:0] digit_reg, digit_next;
  logic       valid_reg, valid_next;
  logic       parity_err_reg, parity_err_next;
  logic       range_err_reg, range_err_next;
  logic [3:0] err_cnt_reg, err_cnt_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S0;
      shift_reg      <= 4'd0;
      digit_reg      <= 4'd0;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      range_err_reg  <= 1'b0;
      err_cnt_reg    <= 4'd0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      digit_reg      <= digit_next;
      valid_reg      <= valid_next;
      parity_err_reg <= parity_err_next;
      range_err_reg  <= range_err_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    digit_next      = digit_reg;
    valid_next      = 1'b0;
    parity_err_next = parity_err_reg;
    range_err_next  = range_err_reg;
    err_cnt_next    = err_cnt_reg;
    if (en) begin
      case (state_reg)
        S0: begin shift_next = {shift_reg[2:0], x}; state_next = S1; end
        S1: begin shift_next = {shift_reg[2:0], x}; state_next = S2; end
        S2: begin shift_next = {shift_reg[2:0], x}; state_next = S3; end
        S3: begin shift_next = {shift_reg[2:0], x}; state_next = S4; end
        S4: begin
          // Frame complete: all five bits are in hand (nibble in shift_reg, parity on x).
          state_next      = S0;
          digit_next      = shift_reg;
          valid_next      = 1'b1;
          parity_err_next = ~(^shift_reg ^ x);
          range_err_next  = (shift_reg > 4'd9);
          if ((parity_err_next || range_err_next) && (err_cnt_reg != 4'd15))
            err_cnt_next = err_cnt_reg + 4'd1;
        end
        default: state_next = S0;
      endcase
    end
  end

  assign digit      = digit_reg;
  assign valid      = valid_reg;
  assign parity_err = parity_err_reg;
  assign range_err  = range_err_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_bcd_opc_checker.sv
// Scoreboard bench for bcd_opc_checker: driver queues expected frame results with
// the cycle they must appear in; a monitor pops and compares on every valid.
module tb_bcd_opc_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0;
  logic       en = 1'b0;
  logic [3:0] digit;
  logic       valid;
  logic       parity_err;
  logic       range_err;
  logic [3:0] err_cnt;

  bcd_opc_checker dut (
    .clock(clock), .reset(reset), .x(x), .en(en),
    .digit(digit), .valid(valid), .parity_err(parity_err),
    .range_err(range_err), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] digit;
    logic       perr;
    logic       rerr;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: a valid must match the head of the queue in the exact cycle expected.
  always @(negedge clock) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("digit", digit, e.digit);
        chk("parity_err", parity_err, e.perr);
        chk("range_err", range_err, e.rerr);
        chk("err_cnt", err_cnt, e.cnt);
        $display("frame: digit=%0d perr=%b rerr=%b cnt=%0d cyc=%0d", digit, parity_err, range_err, err_cnt, cyc);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_valid", 0, 1);
    end
  end

  task automatic send_bit(input logic b);
    en = 1'b1;
    x  = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [4:0] bits, input logic [3:0] d,
                            input logic pe, input logic re, input logic [3:0] c);
    exp_t e;
    for (int i = 4; i >= 0; i--) send_bit(bits[i]);
    e.digit = d; e.perr = pe; e.rerr = re; e.cnt = c; e.cyc = cyc;
    exp_q.push_back(e);
    en = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_rerr"}, range_err, 0);
    chk({tag, "_cnt"}, err_cnt, 0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed frames: bits {b3,b2,b1,b0,p}, digit, perr, rerr, err_cnt
    send_frame(5'b01011, 4'd5,  1'b0, 1'b0, 4'd0);
    send_frame(5'b00110, 4'd3,  1'b1, 1'b0, 4'd1);
    send_frame(5'b10011, 4'd9,  1'b0, 1'b0, 4'd1);
    send_frame(5'b10101, 4'd10, 1'b0, 1'b1, 4'd2);
    send_frame(5'b11110, 4'd15, 1'b1, 1'b1, 4'd3);

    // Stall three cycles before the parity bit; completion slips by exactly three.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("stall_valid", valid, 0);
      chk("stall_digit_hold", digit, 15);
    end
    send_bit(1'b0);
    e.digit = 4'd7; e.perr = 1'b0; e.rerr = 1'b0; e.cnt = 4'd3; e.cyc = cyc;
    exp_q.push_back(e);
    en = 1'b0;
    @(posedge clock); #1;

    // Reset mid-frame: partial frame discarded, everything cleared asynchronously.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    en = 1'b0;
    reset = 1'b0;
    #1;
    check_cleared("midreset");
    @(posedge clock); #1;
    chk("midreset_hold_valid", valid, 0);
    reset = 1'b1;
    send_frame(5'b00100, 4'd2, 1'b0, 1'b0, 4'd0);

    // Saturation: 17 back-to-back parity-error frames with en held high.
    for (int i = 1; i <= 17; i++)
      send_frame(5'b00000, 4'd0, 1'b1, 1'b0, (i > 15) ? 4'd15 : 4'(i));

    repeat (3) @(posedge clock);
    #1;
    chk("final_err_cnt", err_cnt, 15);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_opc_checker.md
# bcd_opc_checker

Serial receive-side checker for the lab's BCD odd-parity serial format. It deserializes 5-bit frames (4 BCD data bits, MSB first, followed by one odd-parity bit) arriving one bit per enabled clock on `x`. For each frame it presents the received digit and flags parity and BCD-range errors. It sits at the far end of the serial BCD/odd-parity link, opposite the parity generator, and keeps a saturating count of bad frames for observation in simulation.

## Interface
- No parameters. Frame length is fixed at 5 and the error counter is fixed at 4 bits.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `x`  in  1  serial data bit. Sampled only when `en`=1.
- `en`  in  1  bit-enable. 1 means `x` carries a valid bit this cycle; 0 means stall.
- `digit`  out  4  last received data nibble, {b3,b2,b1,b0}.
- `valid`  out  1  one-cycle pulse when a frame completes.
- `parity_err`  out  1  completed frame failed the odd-parity check.
- `range_err`  out  1  completed frame's nibble is greater than 9.
- `err_cnt`  out  4  saturating count of frames with any error.

## Operation
- The FSM has five states, S0..S4, where the state is the index of the next bit expected. Order: S0=b3, S1=b2, S2=b1, S3=b0, S4=parity.
- With `en`=1, each state advances: S0→S1→S2→S3→S4→S0. With `en`=0, the state, shift register and held outputs do not change.
- In S0..S3 with `en`=1, shift `x` into a 4-bit shift register, MSB first.
- In S4 with `en`=1, complete the frame:
  - `digit` ← shift register.
  - `valid` ← 1.
  - `parity_err` ← ~(b3^b2^b1^b0^x). A frame is good when the five bits together contain an odd number of ones.
  - `range_err` ← (nibble > 9).
  - If either error is set, `err_cnt` increments, saturating at 15.
- `digit`, `parity_err` and `range_err` hold their values until the next frame completes.
- `valid` is 1 only in the cycle after the completing edge, and 0 otherwise. This includes any cycle where `en`=0.
- There is no resynchronisation. Frame alignment comes only from reset: after reset the first enabled bit is b3.
- Reset values: state=S0, shift register=0, `digit`=0, `valid`=0, `parity_err`=0, `range_err`=0, `err_cnt`=0.
- If reset is asserted mid-frame, the FSM goes immediately (asynchronously) to S0. The partial frame is discarded with no `valid` pulse, and `err_cnt` is cleared.
- Both errors can be set in the same frame; `err_cnt` still increments by only 1.

## Timing
- All outputs are registered and change only on a rising `clock` edge or on asynchronous reset.
- Latency: `valid`, `digit` and the error flags update on the same edge that samples the parity bit. They are visible for the whole following cycle.
- Back-to-back frames with `en` held at 1 give one `valid` pulse every 5 cycles.
- Deasserting `en` for N cycles at any point in a frame delays completion by exactly N cycles.
- After `reset` is released (0→1), the first rising edge with `en`=1 samples b3.

## Test plan
- **Good frame.** Reset, then `en`=1 with `x`=0,1,0,1,1. Required: one `valid` pulse, `digit`=5, `parity_err`=0, `range_err`=0, `err_cnt`=0.
- **Parity error.** Bits 0,0,1,1,0. Required: `digit`=3, `parity_err`=1, `err_cnt`=1. Then bits 1,0,0,1,1. Required: `digit`=9, both flags 0, `err_cnt` unchanged at 1.
- **Range error.** Bits 1,0,1,0,1. Required: `digit`=10, `range_err`=1, `parity_err`=0. Bits 1,1,1,1,0. Required: `digit`=15, both flags 1, `err_cnt` +1.
- **Stall.** Send 0,1,1,1 then hold `en`=0 for 3 cycles, then send parity 0. Required: no `valid` during the stall, `valid` appears 3 cycles later than unstalled, `digit`=7, no errors.
- **Reset mid-frame.** Send 1,1,0, assert `reset`=0, release, then send 0,0,1,0,0. Required: no `valid` before the reset, outputs 0 during reset, then `digit`=2 with no errors.
- **Saturation.** Send 17 consecutive parity-error frames (0,0,0,0,0). Required: `err_cnt` reaches 15 and stays at 15, with `valid` pulsing every 5 cycles.
